prog_mem_arbiter: RTL and testbench

Arbitrates the single-port 1024x18 program memory between the CPU instruction-fetch port and the debug program loader. During normal execution it serves CPU fetches and interleaves loader readback round-robin. On loader request it drains in-flight reads, stalls the CPU, and grants the loader exclusive read/write access for in-system reprogramming. It sits between the RAT CPU fetch stage, the loader front end and the synchronous program memory.

---
 rtl/prog_mem_arbiter_if.sv | 39 +++
 rtl/prog_mem_arbiter.sv | 106 ++++++++++
 tb/tb_prog_mem_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/prog_mem_arbiter_if.sv
// Bus bundle between the CPU fetch stage, the debug loader front end and the
// single-port program memory, as seen by the program memory arbiter.
interface prog_mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 18
);
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_gnt;
  logic [DATA_W-1:0] cpu_ir;
  logic              cpu_valid;
  logic              cpu_stall;
  logic              ld_hold;
  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_gnt;
  logic [DATA_W-1:0] ld_rdata;
  logic              ld_valid;
  logic              ld_active;
  logic [ADDR_W:0]   wr_count;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_addr, ld_hold, ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
    output cpu_gnt, cpu_ir, cpu_valid, cpu_stall, ld_gnt, ld_rdata, ld_valid,
           ld_active, wr_count, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output cpu_req, cpu_addr, ld_hold, ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
    input  cpu_gnt, cpu_ir, cpu_valid, cpu_stall, ld_gnt, ld_rdata, ld_valid,
           ld_active, wr_count, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/prog_mem_arbiter.sv
// Program memory arbiter: round-robin CPU fetch / loader readback in normal
// execution, exclusive loader read/write sessions for in-system reprogramming.
//
// state | meaning
// RUN   | CPU fetches and loader reads share the memory round-robin
// DRAIN | no grants; last read return from RUN is flushed out
// LOAD  | CPU stalled; loader owns the memory for reads and writes
// EXIT  | no grants; last loader read return is flushed out
module prog_mem_arbiter #(
  parameter int ADDR_W = 10
) (
  input logic            clk_i,
  input logic            rst_n_i,
  prog_mem_arbiter_if.slave arb_if
);
  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_EXIT  = 2'd3;

  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_CPU  = 2'd1;
  localparam logic [1:0] TAG_LD   = 2'd2;

  localparam logic [ADDR_W:0] WR_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] WR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]      state_q, state_d;
  logic [1:0]      tag_q, tag_d;
  logic            pri_ld_q, pri_ld_d;
  logic            stall_q;
  logic [ADDR_W:0] wr_cnt_q, wr_cnt_d;
  logic            cpu_gnt, ld_gnt, ld_rd, mem_we;

  assign ld_rd = arb_if.ld_req & ~arb_if.ld_we;

  always_comb begin
    state_d = state_q;
    cpu_gnt = 1'b0;
    ld_gnt  = 1'b0;
    case (state_q)
      S_RUN: begin
        if (arb_if.ld_hold) begin
          state_d = S_DRAIN;
        end else begin
          // pri_ld_q set means the CPU won the last grant, so the loader goes next
          cpu_gnt = arb_if.cpu_req & (~ld_rd | ~pri_ld_q);
          ld_gnt  = ld_rd & (~arb_if.cpu_req | pri_ld_q);
        end
      end
      S_DRAIN: state_d = S_LOAD;
      S_LOAD: begin
        if (!arb_if.ld_hold) state_d = S_EXIT;
        else                 ld_gnt  = arb_if.ld_req;
      end
      S_EXIT:  state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  assign mem_we = ld_gnt & arb_if.ld_we & (state_q == S_LOAD);

  always_comb begin
    pri_ld_d = pri_ld_q;
    if (cpu_gnt)     pri_ld_d = 1'b1;
    else if (ld_gnt) pri_ld_d = 1'b0;

    tag_d = TAG_NONE;
    if (cpu_gnt)    tag_d = TAG_CPU;
    else if (ld_gnt && !arb_if.ld_we) tag_d = TAG_LD;

    wr_cnt_d = wr_cnt_q;
    if (state_q == S_DRAIN)              wr_cnt_d = '0;
    else if (mem_we && wr_cnt_q != WR_MAX) wr_cnt_d = wr_cnt_q + WR_ONE;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_RUN;
      tag_q    <= TAG_NONE;
      pri_ld_q <= 1'b0;
      stall_q  <= 1'b0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      pri_ld_q <= pri_ld_d;
      stall_q  <= (state_d != S_RUN);
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign arb_if.cpu_gnt   = cpu_gnt;
  assign arb_if.ld_gnt    = ld_gnt;
  assign arb_if.cpu_valid = (tag_q == TAG_CPU);
  assign arb_if.ld_valid  = (tag_q == TAG_LD);
  assign arb_if.cpu_ir    = (tag_q == TAG_CPU) ? arb_if.mem_rdata : '0;
  assign arb_if.ld_rdata  = (tag_q == TAG_LD)  ? arb_if.mem_rdata : '0;
  assign arb_if.cpu_stall = stall_q;
  assign arb_if.ld_active = (state_q == S_LOAD);
  assign arb_if.wr_count  = wr_cnt_q;
  assign arb_if.mem_we    = mem_we;
  assign arb_if.mem_wdata = mem_we ? arb_if.ld_wdata : '0;
  assign arb_if.mem_addr  = cpu_gnt ? arb_if.cpu_addr :
                            ld_gnt  ? arb_if.ld_addr  : '0;
endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Scoreboard bench for prog_mem_arbiter with a synchronous 1024x18 memory model.
module tb_prog_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prog_mem_arbiter_if #(.ADDR_W(10), .DATA_W(18)) bus ();
  prog_mem_arbiter #(.ADDR_W(10)) dut (.clk_i(clk), .rst_n_i(rst_n), .arb_if(bus));

  typedef struct packed {
    logic        is_ld;
    logic [17:0] data;
  } sb_t;

  logic [17:0] mem     [1024];
  logic [17:0] ref_mem [1024];
  sb_t         sb [$];
  int          n_tot = 0;
  int          n_bad = 0;

  function automatic logic [17:0] rom_val(input int a);
    return 18'(a * 37 + 'h12345);
  endfunction

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic cr, input logic [9:0] ca, input logic lh, input logic lr,
                       input logic lw, input logic [9:0] la, input logic [17:0] lwd);
    bus.cpu_req  = cr;
    bus.cpu_addr = ca;
    bus.ld_hold  = lh;
    bus.ld_req   = lr;
    bus.ld_we    = lw;
    bus.ld_addr  = la;
    bus.ld_wdata = lwd;
  endtask

  // One clock cycle: check returns due now and this cycle's grants, then
  // record what the granted accesses should produce.
  task automatic step(input logic cg, input logic lg, input logic st, input logic ac);
    sb_t it;
    @(negedge clk);
    if (sb.size() > 0) begin
      it = sb.pop_front();
      chk("cpu_valid", bus.cpu_valid, !it.is_ld);
      chk("ld_valid", bus.ld_valid, it.is_ld);
      if (it.is_ld) chk("ld_rdata", bus.ld_rdata, it.data);
      else          chk("cpu_ir", bus.cpu_ir, it.data);
    end else begin
      chk("cpu_valid_idle", bus.cpu_valid, 0);
      chk("ld_valid_idle", bus.ld_valid, 0);
    end
    chk("cpu_gnt", bus.cpu_gnt, cg);
    chk("ld_gnt", bus.ld_gnt, lg);
    chk("cpu_stall", bus.cpu_stall, st);
    chk("ld_active", bus.ld_active, ac);
    chk("mem_we", bus.mem_we, lg && bus.ld_we);
    if (cg) begin
      chk("mem_addr_cpu", bus.mem_addr, bus.cpu_addr);
      sb.push_back('{is_ld: 1'b0, data: ref_mem[bus.cpu_addr]});
    end else if (lg) begin
      chk("mem_addr_ld", bus.mem_addr, bus.ld_addr);
      if (bus.ld_we) ref_mem[bus.ld_addr] = bus.ld_wdata;
      else           sb.push_back('{is_ld: 1'b1, data: ref_mem[bus.ld_addr]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero();
    chk("rst_cpu_gnt", bus.cpu_gnt, 0);
    chk("rst_ld_gnt", bus.ld_gnt, 0);
    chk("rst_cpu_valid", bus.cpu_valid, 0);
    chk("rst_ld_valid", bus.ld_valid, 0);
    chk("rst_cpu_stall", bus.cpu_stall, 0);
    chk("rst_ld_active", bus.ld_active, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_cpu_ir", bus.cpu_ir, 0);
    chk("rst_ld_rdata", bus.ld_rdata, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_wr_count", bus.wr_count, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = rom_val(i);
      ref_mem[i] = rom_val(i);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Plain CPU fetch stream
    for (int i = 0; i < 8; i++) begin
      drive(1, 10'(i), 0, 0, 0, 0, 0);
      step(1, 0, 0, 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Lone loader read, then contested requests alternate starting with the CPU
    drive(0, 0, 0, 1, 0, 10'h3FF, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(1, 10'(32 + i), 0, 1, 0, 10'h3FF, 0);
      step(i % 2 == 0, i % 2 == 1, 0, 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0);

    // CPU read, then session entry; loader write is refused outside LOAD
    drive(1, 10'h005, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0);
    drive(1, 10'h005, 1, 1, 1, 10'h010, 18'h2A5A5);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 1, 1, 1);
    drive(1, 10'h005, 1, 1, 0, 10'h010, 0);
    step(0, 1, 1, 1);
    chk("wr_count_one", bus.wr_count, 1);

    // Bulk writes across the whole array to hit the counter saturation
    for (int i = 0; i < 1030; i++) begin
      drive(1, 10'h005, 1, 1, 1, 10'(i + 'h100), 18'(i * 5 + 7));
      step(0, 1, 1, 1);
      if (i == 1021) chk("wr_count_1023", bus.wr_count, 1023);
      if (i == 1022) chk("wr_count_sat", bus.wr_count, 1024);
    end
    chk("wr_count_end", bus.wr_count, 1024);
    for (int i = 0; i < 4; i++) begin
      drive(1, 10'h005, 1, 1, 0, 10'(i * 200 + 3), 0);
      step(0, 1, 1, 1);
    end
    drive(1, 10'h005, 1, 1, 1, 10'h010, 18'h2A5A5);
    step(0, 1, 1, 1);

    // Session exit and CPU fetch of the reprogrammed word
    drive(1, 10'h010, 0, 1, 0, 10'h3FF, 0);
    step(0, 0, 1, 1);
    drive(1, 10'h010, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("wr_count_hold", bus.wr_count, 1024);

    // New session, loader read, then reset while its return is due
    drive(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("wr_count_clr", bus.wr_count, 0);
    drive(0, 0, 1, 1, 0, 10'h3FF, 0);
    step(0, 1, 1, 1);
    rst_n = 1'b0;
    sb.delete();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_ld_valid_now", bus.ld_valid, 0);
    chk("rst_active_now", bus.ld_active, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_zero();
    @(posedge clk);
    #1;
    step(0, 0, 0, 0);
    drive(1, 10'h003, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
